// File: rtl/mul_seq_pkg.sv
// Shared definitions for the multi-cycle multiply sequencer: op codes,
// FSM state encoding and a helper that recognises multiply requests.
package mul_seq_pkg;

  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_UMULL = 3'b101;
  localparam logic [2:0] OP_SMULL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // True for the three op codes this engine executes.
  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL);
  endfunction

endpackage

// File: rtl/mul_seq_datapath.sv
// Radix-2 shift-add datapath: operand capture (with magnitude conversion for
// signed multiplies), W+1-bit accumulate, combined right shift, and the final
// sign fix-up that produces the registered results and {N,Z} flags.
module mul_seq_datapath
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_fix,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [1:0]       o_flags
);

  logic [WIDTH-1:0]        r_mcand;
  logic [WIDTH-1:0]        r_acc;
  logic [WIDTH-1:0]        r_mplier;
  logic                    r_neg;
  logic                    r_is_mul;

  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic [WIDTH-1:0]        w_a_abs;
  logic [WIDTH-1:0]        w_b_abs;
  logic [WIDTH-1:0]        w_addend;
  logic [WIDTH:0]          w_sum;
  logic [2*WIDTH-1:0]      w_prod;
  logic [2*WIDTH-1:0]      w_fixed;
  logic [WIDTH-1:0]        w_res_hi;
  logic [WIDTH-1:0]        w_res_lo;

  // Negate a full-width product when the operand signs differed.
  function automatic logic [2*WIDTH-1:0] sign_fix(input logic [2*WIDTH-1:0] p,
                                                   input logic neg);
    return neg ? (~p + 1'b1) : p;
  endfunction

  // {N,Z}: N comes from the top bit of the reported result, Z covers all of it.
  function automatic logic [1:0] calc_flags(input logic [WIDTH-1:0] hi,
                                            input logic [WIDTH-1:0] lo,
                                            input logic is_mul);
    logic n;
    logic z;
    n = is_mul ? lo[WIDTH-1] : hi[WIDTH-1];
    z = ({hi, lo} == '0);
    return {n, z};
  endfunction

  // The most negative value maps to 2**(W-1), which is exact as unsigned.
  assign w_a_s    = i_a;
  assign w_b_s    = i_b;
  assign w_a_abs  = w_a_s[WIDTH-1] ? -w_a_s : w_a_s;
  assign w_b_abs  = w_b_s[WIDTH-1] ? -w_b_s : w_b_s;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};

  assign w_prod   = {r_acc, r_mplier};
  assign w_fixed  = sign_fix(w_prod, r_neg);
  assign w_res_hi = r_is_mul ? '0 : w_fixed[2*WIDTH-1:WIDTH];
  assign w_res_lo = w_fixed[WIDTH-1:0];

  // Operand capture on load; one add-and-shift iteration per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_is_mul <= 1'b0;
    end else if (i_load) begin
      r_is_mul <= (i_op == OP_MUL);
      r_acc    <= '0;
      if (i_op == OP_SMULL) begin
        r_mcand  <= w_a_abs;
        r_mplier <= w_b_abs;
        r_neg    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      end else begin
        r_mcand  <= i_a;
        r_mplier <= i_b;
        r_neg    <= 1'b0;
      end
    end else if (i_step) begin
      r_acc    <= w_sum[WIDTH:1];
      r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
    end
  end

  // Results and flags update only on the fix strobe and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_hi    <= '0;
      o_lo    <= '0;
      o_flags <= 2'b00;
    end else if (i_fix) begin
      o_hi    <= w_res_hi;
      o_lo    <= w_res_lo;
      o_flags <= calc_flags(w_res_hi, w_res_lo, r_is_mul);
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply controller: IDLE -> RUN (WIDTH iterations) -> SIGN -> DONE.
// Owns the FSM and the iteration counter; the arithmetic lives in mul_seq_datapath.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic [1:0]       flags
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_step;
  logic             w_fix;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Iteration counter: cleared on accept, advanced once per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_cnt <= '0;
    else if (w_load) r_cnt <= '0;
    else if (w_step) r_cnt <= r_cnt + 1'b1;
  end

  // Next-state logic, datapath strobes and status outputs.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && is_mul_op(op)) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == LAST_ITER) w_next = S_SIGN;
      end
      S_SIGN: begin
        busy   = 1'b1;
        w_fix  = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  mul_seq_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk     (clk),
    .rst     (reset),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_fix   (w_fix),
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .o_hi    (result_hi),
    .o_lo    (result_lo),
    .o_flags (flags)
  );

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed scenarios plus randomized operations
// checked against an arithmetic reference model.
module tb_mul_sequencer;

  localparam int W = 32;
  localparam logic [2:0] T_MUL   = 3'b100;
  localparam logic [2:0] T_UMULL = 3'b101;
  localparam logic [2:0] T_SMULL = 3'b110;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result_hi;
  logic [W-1:0] result_lo;
  logic [1:0]   flags;

  int n_cmp = 0;
  int n_bad = 0;

  mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: products from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] ehi, output logic [W-1:0] elo, output logic [1:0] efl);
    longint          sa, sb;
    longint unsigned p;
    if (mop == T_SMULL) begin
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      p  = longint'(sa * sb);
    end else begin
      p  = longint'({32'd0, ma}) * longint'({32'd0, mb});
    end
    elo = p[31:0];
    ehi = (mop == T_MUL) ? 32'd0 : p[63:32];
    efl[1] = (mop == T_MUL) ? elo[31] : ehi[31];
    efl[0] = ({ehi, elo} == 64'd0);
  endtask

  // Issue one op and check latency, busy length, results, pulse width and hold.
  task automatic run_op(input string tag, input logic [2:0] top, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input bit inject);
    logic [W-1:0] ehi, elo;
    logic [1:0]   efl;
    int n, busy_n;
    model(top, ta, tb, ehi, elo, efl);
    op = top; a = ta; b = tb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    n = 0; busy_n = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      if (inject && n == 10) begin
        start = 1'b1; op = T_UMULL; a = $urandom; b = $urandom;
      end else if (inject && n == 11) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(W + 1));
    check({tag, "_busy"}, 64'(busy_n), 64'(W + 1));
    check({tag, "_hi"}, 64'(result_hi), 64'(ehi));
    check({tag, "_lo"}, 64'(result_lo), 64'(elo));
    check({tag, "_flags"}, 64'(flags), 64'(efl));
    if (inject) begin
      start = 1'b1; op = T_UMULL; a = $urandom; b = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_pulse"}, 64'({busy, done}), 64'(2'b00));
    check({tag, "_hold"}, {result_hi, result_lo}, {ehi, elo});
  endtask

  initial begin
    logic [W-1:0] pick [5];
    int cnt_busy, cnt_done;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_res", {result_hi, result_lo}, 64'd0);
    check("rst_flags", 64'(flags), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op("mul_3x5", T_MUL, 32'd3, 32'd5, 1'b0);
    check("mul_3x5_const", 64'(result_lo), 64'h0F);
    run_op("umull_max", T_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("umull_max_const", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("smull_m2x3", T_SMULL, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("smull_m2x3_const", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("smull_min", T_SMULL, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("smull_min_const", {result_hi, result_lo}, 64'h4000_0000_0000_0000);
    run_op("mul_zero", T_MUL, 32'd0, 32'h1234, 1'b0);
    check("mul_zero_z", 64'(flags), 64'(2'b01));

    // Invalid op held with start: nothing happens
    op = 3'b010; start = 1'b1; a = 32'd9; b = 32'd9;
    cnt_busy = 0; cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy) cnt_busy++;
      if (done) cnt_done++;
    end
    start = 1'b0;
    check("badop_busy", 64'(cnt_busy), 64'(0));
    check("badop_done", 64'(cnt_done), 64'(0));

    // Start pulses while busy and during DONE are ignored
    run_op("umull_ign", T_UMULL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

    // Reset mid-operation aborts without a done pulse
    op = T_UMULL; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_res", {result_hi, result_lo}, 64'd0);
    check("abort_flags", 64'(flags), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    cnt_done = 0; cnt_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    check("abort_nodone", 64'(cnt_done), 64'(0));
    check("abort_nobusy", 64'(cnt_busy), 64'(0));
    run_op("mul_7x6", T_MUL, 32'd7, 32'd6, 1'b0);
    check("mul_7x6_const", 64'(result_lo), 64'd42);

    // Randomized operations, operands biased toward corner values
    for (int k = 0; k < 24; k++) begin
      logic [2:0]   rop;
      logic [W-1:0] ra, rb;
      pick[0] = 32'd0; pick[1] = 32'd1; pick[2] = 32'hFFFF_FFFF;
      pick[3] = 32'h8000_0000; pick[4] = $urandom;
      case ($urandom_range(0, 2))
        0:       rop = T_MUL;
        1:       rop = T_UMULL;
        default: rop = T_SMULL;
      endcase
      ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      run_op($sformatf("rnd%0d", k), rop, ra, rb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
